// File: rtl/sh7604_ibus_initiator.sv
// sh7604_ibus_initiator
//   Initiator end of the SH7604 on-chip peripheral bus (IBUS). One CPU-side
//   byte/word/long access to the FFFFFE00-FFFFFFFF register window is run as
//   a single IBUS transaction. The initiator steers byte lanes on writes and
//   returns right-justified, zero-extended data on reads.
//
//   Optional feature macro: SH7604_IBUS_TIMEOUT_EN. When it is defined, an
//   access is aborted with a BUS_ERR pulse after TIMEOUT consecutive CE_R
//   cycles of IBUS_BUSY. When it is undefined, ACCESS waits indefinitely and
//   BUS_ERR is tied low.
//
// Ports
//   CLK, RST         system clock, asynchronous active-high reset
//   CE_R, CE_F       rising/falling phase enables (state moves on CE_R only)
//   RES_N            synchronous manual reset, active-low, sampled on CE_R
//   CPU_A/DI/SZ/WE   access address, right-justified write data, size, write
//   CPU_REQ          access request, held until CPU_BUSY is low
//   CPU_DO           read data, right-justified and zero-extended
//   CPU_BUSY         stall back to the CPU
//   ADDR_ERR         one-CE_R pulse on a misaligned access
//   BUS_ERR          one-CE_R pulse on an IBUS timeout
//   IBUS_A/DO/BA     transaction address, lane-replicated data, lane enables
//   IBUS_WE/REQ      write strobe, transaction request
//   IBUS_DI          OR of the responders' read data
//   IBUS_BUSY        responder wait
//   IBUS_ACT         a responder decodes IBUS_A
//
// State    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | no access in flight; waits for a selected CPU request
// ST_ACCESS| IBUS_REQ high from latched registers; waits out IBUS_BUSY
// ST_DONE  | releases the CPU for one CE_R, then returns to ST_IDLE

module sh7604_ibus_initiator #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CE_R,
    input  logic        CE_F,
    input  logic        RES_N,
    input  logic [31:0] CPU_A,
    input  logic [31:0] CPU_DI,
    input  logic [1:0]  CPU_SZ,
    input  logic        CPU_WE,
    input  logic        CPU_REQ,
    output logic [31:0] CPU_DO,
    output logic        CPU_BUSY,
    output logic        ADDR_ERR,
    output logic        BUS_ERR,
    output logic [31:0] IBUS_A,
    output logic [31:0] IBUS_DO,
    output logic [3:0]  IBUS_BA,
    output logic        IBUS_WE,
    output logic        IBUS_REQ,
    input  logic [31:0] IBUS_DI,
    input  logic        IBUS_BUSY,
    input  logic        IBUS_ACT
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] a_q, a_d;
    logic [31:0] do_q, do_d;
    logic [3:0]  ba_q, ba_d;
    logic [1:0]  sz_q, sz_d;
    logic        we_q, we_d;
    logic [31:0] cpu_do_q, cpu_do_d;
    logic        addr_err_q, addr_err_d;
`ifdef SH7604_IBUS_TIMEOUT_EN
    logic [7:0]  cnt_q, cnt_d;
    logic        bus_err_q, bus_err_d;
`endif

    logic        sel;
    logic        misaligned;
    logic [3:0]  lane_ba;
    logic [31:0] lane_do;
    logic [31:0] rd_data;

    // Request decode and lane steering for the access presented by the CPU.
    always_comb begin
        sel        = CPU_REQ && (CPU_A[31:9] == 23'h7FFFFF);
        misaligned = 1'b0;
        lane_ba    = 4'b1111;
        lane_do    = CPU_DI;
        case (CPU_SZ)
            2'b00: begin
                lane_ba = 4'b1000 >> CPU_A[1:0];
                lane_do = {4{CPU_DI[7:0]}};
            end
            2'b01: begin
                misaligned = CPU_A[0];
                lane_ba    = CPU_A[1] ? 4'b0011 : 4'b1100;
                lane_do    = {2{CPU_DI[15:0]}};
            end
            default: begin
                // 2'b11 is reserved and behaves as a long access
                misaligned = (CPU_A[1:0] != 2'b00);
            end
        endcase
    end

    // Right-justify the addressed big-endian lane of the responder data.
    always_comb begin
        rd_data = IBUS_DI;
        case (sz_q)
            2'b00: begin
                case (a_q[1:0])
                    2'b00:   rd_data = {24'd0, IBUS_DI[31:24]};
                    2'b01:   rd_data = {24'd0, IBUS_DI[23:16]};
                    2'b10:   rd_data = {24'd0, IBUS_DI[15:8]};
                    default: rd_data = {24'd0, IBUS_DI[7:0]};
                endcase
            end
            2'b01:   rd_data = a_q[1] ? {16'd0, IBUS_DI[15:0]} : {16'd0, IBUS_DI[31:16]};
            default: rd_data = IBUS_DI;
        endcase
        if (!IBUS_ACT) begin
            rd_data = 32'd0;
        end
    end

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        do_d       = do_q;
        ba_d       = ba_q;
        sz_d       = sz_q;
        we_d       = we_q;
        cpu_do_d   = cpu_do_q;
        addr_err_d = addr_err_q;
`ifdef SH7604_IBUS_TIMEOUT_EN
        cnt_d      = cnt_q;
        bus_err_d  = bus_err_q;
`endif
        if (CE_R) begin
            // error strobes last exactly one CE_R period
            addr_err_d = 1'b0;
`ifdef SH7604_IBUS_TIMEOUT_EN
            bus_err_d  = 1'b0;
`endif
            if (!RES_N) begin
                state_d  = ST_IDLE;
                a_d      = 32'd0;
                do_d     = 32'd0;
                ba_d     = 4'd0;
                sz_d     = 2'd0;
                we_d     = 1'b0;
                cpu_do_d = 32'd0;
`ifdef SH7604_IBUS_TIMEOUT_EN
                cnt_d    = 8'd0;
`endif
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (sel) begin
                            a_d      = CPU_A;
                            do_d     = lane_do;
                            ba_d     = lane_ba;
                            sz_d     = CPU_SZ;
                            we_d     = CPU_WE;
                            cpu_do_d = 32'd0;
`ifdef SH7604_IBUS_TIMEOUT_EN
                            cnt_d    = 8'd0;
`endif
                            if (misaligned) begin
                                state_d    = ST_DONE;
                                addr_err_d = 1'b1;
                            end else begin
                                state_d = ST_ACCESS;
                            end
                        end
                    end
                    ST_ACCESS: begin
                        if (!IBUS_BUSY) begin
                            state_d = ST_DONE;
                            if (!we_q) begin
                                cpu_do_d = rd_data;
                            end
                        end else begin
`ifdef SH7604_IBUS_TIMEOUT_EN
                            if ((cnt_q + 8'd1) == TIMEOUT[7:0]) begin
                                state_d   = ST_DONE;
                                bus_err_d = 1'b1;
                                cpu_do_d  = 32'd0;
                            end else begin
                                cnt_d = cnt_q + 8'd1;
                            end
`endif
                        end
                    end
                    ST_DONE: state_d = ST_IDLE;
                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            a_q        <= 32'd0;
            do_q       <= 32'd0;
            ba_q       <= 4'd0;
            sz_q       <= 2'd0;
            we_q       <= 1'b0;
            cpu_do_q   <= 32'd0;
            addr_err_q <= 1'b0;
`ifdef SH7604_IBUS_TIMEOUT_EN
            cnt_q      <= 8'd0;
            bus_err_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            do_q       <= do_d;
            ba_q       <= ba_d;
            sz_q       <= sz_d;
            we_q       <= we_d;
            cpu_do_q   <= cpu_do_d;
            addr_err_q <= addr_err_d;
`ifdef SH7604_IBUS_TIMEOUT_EN
            cnt_q      <= cnt_d;
            bus_err_q  <= bus_err_d;
`endif
        end
    end

    assign IBUS_REQ = (state_q == ST_ACCESS);
    assign IBUS_WE  = (state_q == ST_ACCESS) && we_q;
    assign IBUS_A   = a_q;
    assign IBUS_DO  = do_q;
    assign IBUS_BA  = ba_q;
    assign CPU_DO   = cpu_do_q;
    assign CPU_BUSY = sel && (state_q != ST_DONE);
    assign ADDR_ERR = addr_err_q;

`ifdef SH7604_IBUS_TIMEOUT_EN
    assign BUS_ERR = bus_err_q;
`else
    assign BUS_ERR = 1'b0;
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT;
`endif

    // Read data is simply sampled on the CE_R that ends ACCESS; CE_F is
    // only meaningful to the responders.
    logic unused_ce_f;
    assign unused_ce_f = CE_F;

endmodule
